// File: rtl/eucl_pkg.sv
`default_nettype none
// ============================================================================
// Module  : eucl_pkg
// Brief   : Shared widths, instruction constants and fetch FSM encoding.
// Revision: 1.0
// ============================================================================
package eucl_pkg;

   localparam int INSTR_W = 21;
   localparam int PC_W    = 4;

   localparam logic [INSTR_W-1:0] NOP_WORD  = 21'h000000;
   localparam logic [INSTR_W-1:0] HALT_WORD = 21'h1FFFFF;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } fetch_state_t;

   // Issued-instruction counter sticks at its ceiling instead of wrapping.
   function automatic logic [7:0] sat_inc8(input logic [7:0] value);
      return (value == 8'hFF) ? value : value + 8'd1;
   endfunction

endpackage : eucl_pkg
`default_nettype wire

// File: rtl/eucl_prog_rom.sv
`default_nettype none
// ============================================================================
// Module  : eucl_prog_rom
// Brief   : Program store, synchronous write port, combinational read port.
// Revision: 1.0
// ============================================================================
module eucl_prog_rom
   import eucl_pkg::*;
(
   input  logic               clock,
   input  logic               we,
   input  logic [PC_W-1:0]    waddr,
   input  logic [INSTR_W-1:0] wdata,
   input  logic [PC_W-1:0]    raddr,
   output logic [INSTR_W-1:0] rdata
);

   localparam int DEPTH = 2 ** PC_W;

   // Contents deliberately survive reset so a program outlives an abort.
   logic [INSTR_W-1:0] r_mem [DEPTH];

   always_ff @(posedge clock) begin
      if (we) begin
         r_mem[waddr] <= wdata;
      end
   end

   assign rdata = r_mem[raddr];

endmodule : eucl_prog_rom
`default_nettype wire

// File: rtl/eucl_prog_fetch.sv
`default_nettype none
// ============================================================================
// Module  : eucl_prog_fetch
// Brief   : Program memory fetch sequencer feeding the eucl core's PC/instr.
// Revision: 1.0
// ============================================================================
module eucl_prog_fetch
   import eucl_pkg::*;
#(
   parameter logic [7:0] MAX_CYCLES = 8'd200
)(
   input  logic               clock,
   input  logic               reset,
   input  logic               ld_en,
   input  logic [PC_W-1:0]    ld_addr,
   input  logic [INSTR_W-1:0] ld_data,
   input  logic               start,
   input  logic [PC_W-1:0]    pc_req,
   output logic [PC_W-1:0]    p_c,
   output logic [INSTR_W-1:0] pm_cont,
   output logic               running,
   output logic               done,
   output logic               timeout,
   output logic [7:0]         cycle_cnt
);

   fetch_state_t       r_state,     w_state_nxt;
   logic [PC_W-1:0]    r_p_c,       w_p_c_nxt;
   logic [INSTR_W-1:0] r_pm_cont,   w_pm_cont_nxt;
   logic               r_running,   w_running_nxt;
   logic               r_done,      w_done_nxt;
   logic               r_timeout,   w_timeout_nxt;
   logic [7:0]         r_cycle_cnt, w_cycle_cnt_nxt;

   logic               w_mem_we;
   logic [PC_W-1:0]    w_rd_addr;
   logic [INSTR_W-1:0] w_rd_data;
   logic               w_in_run;

   assign w_in_run  = (r_state == ST_RUN);
   assign w_mem_we  = ld_en && !w_in_run;
   // Outside RUN the only possible fetch is the restart at address 0.
   assign w_rd_addr = w_in_run ? pc_req : '0;

   eucl_prog_rom u_rom (
      .clock (clock),
      .we    (w_mem_we),
      .waddr (ld_addr),
      .wdata (ld_data),
      .raddr (w_rd_addr),
      .rdata (w_rd_data)
   );

   always_ff @(posedge clock) begin
      if (reset) begin
         r_state     <= ST_IDLE;
         r_p_c       <= '0;
         r_pm_cont   <= NOP_WORD;
         r_running   <= 1'b0;
         r_done      <= 1'b0;
         r_timeout   <= 1'b0;
         r_cycle_cnt <= 8'd0;
      end else begin
         r_state     <= w_state_nxt;
         r_p_c       <= w_p_c_nxt;
         r_pm_cont   <= w_pm_cont_nxt;
         r_running   <= w_running_nxt;
         r_done      <= w_done_nxt;
         r_timeout   <= w_timeout_nxt;
         r_cycle_cnt <= w_cycle_cnt_nxt;
      end
   end

   always_comb begin
      w_state_nxt     = r_state;
      w_p_c_nxt       = r_p_c;
      w_pm_cont_nxt   = r_pm_cont;
      w_running_nxt   = r_running;
      w_done_nxt      = r_done;
      w_timeout_nxt   = r_timeout;
      w_cycle_cnt_nxt = r_cycle_cnt;

      case (r_state)
         ST_IDLE, ST_HALT: begin
            // A load in the same cycle wins so the first fetch never races it.
            if (start && !ld_en) begin
               w_state_nxt     = ST_RUN;
               w_p_c_nxt       = '0;
               w_pm_cont_nxt   = w_rd_data;
               w_running_nxt   = 1'b1;
               w_done_nxt      = 1'b0;
               w_timeout_nxt   = 1'b0;
               w_cycle_cnt_nxt = 8'd1;
            end
         end
         ST_RUN: begin
            if (w_rd_data == HALT_WORD) begin
               w_state_nxt     = ST_HALT;
               w_p_c_nxt       = pc_req;
               w_pm_cont_nxt   = NOP_WORD;
               w_running_nxt   = 1'b0;
               w_done_nxt      = 1'b1;
               w_cycle_cnt_nxt = sat_inc8(r_cycle_cnt);
            end else if (r_cycle_cnt == MAX_CYCLES) begin
               w_state_nxt     = ST_HALT;
               w_pm_cont_nxt   = NOP_WORD;
               w_running_nxt   = 1'b0;
               w_timeout_nxt   = 1'b1;
            end else begin
               w_p_c_nxt       = pc_req;
               w_pm_cont_nxt   = w_rd_data;
               w_cycle_cnt_nxt = sat_inc8(r_cycle_cnt);
            end
         end
         default: begin
            w_state_nxt   = ST_IDLE;
            w_pm_cont_nxt = NOP_WORD;
            w_running_nxt = 1'b0;
         end
      endcase
   end

   assign p_c       = r_p_c;
   assign pm_cont   = r_pm_cont;
   assign running   = r_running;
   assign done      = r_done;
   assign timeout   = r_timeout;
   assign cycle_cnt = r_cycle_cnt;

endmodule : eucl_prog_fetch
`default_nettype wire

// File: tb/tb_eucl_prog_fetch.sv
`default_nettype none
// ============================================================================
// Module  : tb_eucl_prog_fetch
// Brief   : Directed scoreboard bench for eucl_prog_fetch (MAX_CYCLES = 10).
// Revision: 1.0
// ============================================================================
module tb_eucl_prog_fetch;
   import eucl_pkg::*;

   localparam logic [INSTR_W-1:0] M0   = 21'b010101000110000000010;
   localparam logic [INSTR_W-1:0] M1   = 21'b010101000110000001010;
   localparam logic [INSTR_W-1:0] M2L  = 21'b010101000110000000111;
   localparam logic [INSTR_W-1:0] NEWW = 21'h0ABCDE;
   localparam logic [INSTR_W-1:0] NOP  = NOP_WORD;
   localparam logic [INSTR_W-1:0] HLT  = HALT_WORD;

   typedef struct {
      string              name;
      logic [PC_W-1:0]    pc;
      logic [INSTR_W-1:0] instr;
      logic               run;
      logic               dn;
      logic               to;
      logic [7:0]         cnt;
   } exp_t;

   logic               clock;
   logic               reset;
   logic               ld_en;
   logic [PC_W-1:0]    ld_addr;
   logic [INSTR_W-1:0] ld_data;
   logic               start;
   logic [PC_W-1:0]    pc_req;
   logic [PC_W-1:0]    p_c;
   logic [INSTR_W-1:0] pm_cont;
   logic               running;
   logic               done;
   logic               timeout;
   logic [7:0]         cycle_cnt;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   eucl_prog_fetch #(.MAX_CYCLES(8'd10)) dut (
      .clock     (clock),
      .reset     (reset),
      .ld_en     (ld_en),
      .ld_addr   (ld_addr),
      .ld_data   (ld_data),
      .start     (start),
      .pc_req    (pc_req),
      .p_c       (p_c),
      .pm_cont   (pm_cont),
      .running   (running),
      .done      (done),
      .timeout   (timeout),
      .cycle_cnt (cycle_cnt)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Clock one edge with the currently driven inputs; queue the result expected after it.
   task automatic tick(input string name, input bit chk, input logic [PC_W-1:0] pc,
                       input logic [INSTR_W-1:0] instr, input logic run, input logic dn,
                       input logic to, input logic [7:0] cnt);
      exp_t e;
      @(posedge clock);
      if (chk) begin
         e.name = name; e.pc = pc; e.instr = instr;
         e.run = run; e.dn = dn; e.to = to; e.cnt = cnt;
         exp_q.push_back(e);
      end
      #1;
   endtask

   task automatic load(input logic [PC_W-1:0] a, input logic [INSTR_W-1:0] d,
                       input logic [PC_W-1:0] pc, input logic dn, input logic to,
                       input logic [7:0] cnt);
      ld_en = 1'b1; ld_addr = a; ld_data = d; start = 1'b0;
      tick("load_hold", 1'b1, pc, NOP, 1'b0, dn, to, cnt);
      ld_en = 1'b0;
   endtask

   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (p_c !== e.pc || pm_cont !== e.instr || running !== e.run ||
                done !== e.dn || timeout !== e.to || cycle_cnt !== e.cnt) begin
               errors++;
               $display("FAIL %s: got pc=%0d pm=%h run=%b done=%b to=%b cnt=%0d, want pc=%0d pm=%h run=%b done=%b to=%b cnt=%0d",
                        e.name, p_c, pm_cont, running, done, timeout, cycle_cnt,
                        e.pc, e.instr, e.run, e.dn, e.to, e.cnt);
            end
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, want finish before 100000");
      $fatal(1);
   end

   initial begin
      reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0; start = 1'b0; pc_req = '0;
      tick("reset", 1'b0, 0, NOP, 0, 0, 0, 0);
      tick("reset", 1'b1, 0, NOP, 0, 0, 0, 0);
      reset = 1'b0;

      // Straight-line program ending in HALT; core asks for p_c+1
      load(4'd0, M0, 0, 0, 0, 0);
      load(4'd1, M1, 0, 0, 0, 0);
      load(4'd2, HLT, 0, 0, 0, 0);
      start = 1'b1;
      tick("t1_mem0", 1'b1, 0, M0, 1, 0, 0, 1);
      start = 1'b0; pc_req = 4'd1;
      tick("t1_mem1", 1'b1, 1, M1, 1, 0, 0, 2);
      pc_req = 4'd2;
      tick("t1_halt", 1'b1, 2, NOP, 0, 1, 0, 3);
      pc_req = 4'd5;
      tick("t1_frozen", 1'b1, 2, NOP, 0, 1, 0, 3);

      // Loop on address 2, then jump back to 1, then HALT at 3
      load(4'd2, M2L, 2, 1, 0, 3);
      load(4'd3, HLT, 2, 1, 0, 3);
      start = 1'b1;
      tick("t2_restart", 1'b1, 0, M0, 1, 0, 0, 1);
      start = 1'b0; pc_req = 4'd2;
      for (int i = 0; i < 7; i++)
         tick("t2_loop", 1'b1, 2, M2L, 1, 0, 0, 8'(2 + i));
      pc_req = 4'd1;
      tick("t2_jump", 1'b1, 1, M1, 1, 0, 0, 9);
      pc_req = 4'd3;
      tick("t2_halt", 1'b1, 3, NOP, 0, 1, 0, 10);

      // HALT_WORD fetched on the same edge the budget runs out: done wins
      start = 1'b1;
      tick("tie_restart", 1'b1, 0, M0, 1, 0, 0, 1);
      start = 1'b0; pc_req = 4'd2;
      for (int i = 0; i < 8; i++)
         tick("tie_loop", 1'b1, 2, M2L, 1, 0, 0, 8'(2 + i));
      pc_req = 4'd1;
      tick("tie_cnt10", 1'b1, 1, M1, 1, 0, 0, 10);
      pc_req = 4'd3;
      tick("tie_halt", 1'b1, 3, NOP, 0, 1, 0, 11);

      // Timeout run; loads and start during RUN must be ignored
      start = 1'b1;
      tick("t3_restart", 1'b1, 0, M0, 1, 0, 0, 1);
      pc_req = 4'd2; ld_en = 1'b1; ld_addr = 4'd0; ld_data = NEWW;
      for (int i = 0; i < 9; i++)
         tick("t3_run", 1'b1, 2, M2L, 1, 0, 0, 8'(2 + i));
      start = 1'b0; ld_en = 1'b0;
      tick("t3_timeout", 1'b1, 2, NOP, 0, 0, 1, 10);
      tick("t3_frozen", 1'b1, 2, NOP, 0, 0, 1, 10);
      start = 1'b1;
      tick("t4_restart", 1'b1, 0, M0, 1, 0, 0, 1);
      start = 1'b0;
      tick("t4_fetch", 1'b1, 2, M2L, 1, 0, 0, 2);

      // Reset mid-RUN aborts; program survives
      reset = 1'b1;
      tick("t6_reset", 1'b1, 0, NOP, 0, 0, 0, 0);
      reset = 1'b0; start = 1'b1;
      tick("t6_restart", 1'b1, 0, M0, 1, 0, 0, 1);
      start = 1'b0; pc_req = 4'd1;
      tick("t6_mem1", 1'b1, 1, M1, 1, 0, 0, 2);

      // start with ld_en in IDLE: write only, then start sees the new word
      reset = 1'b1;
      tick("t5_reset", 1'b1, 0, NOP, 0, 0, 0, 0);
      reset = 1'b0; start = 1'b1; ld_en = 1'b1; ld_addr = 4'd0; ld_data = NEWW;
      tick("t5_ld_start", 1'b1, 0, NOP, 0, 0, 0, 0);
      ld_en = 1'b0;
      tick("t5_newword", 1'b1, 0, NEWW, 1, 0, 0, 1);
      start = 1'b0;

      repeat (3) @(posedge clock);
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d expectations left unchecked, want 0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_eucl_prog_fetch
`default_nettype wire
